// File: rtl/vga_text_wr_pkg.sv
// Shared types and constants for the VGA text-mode Avalon-MM writer.
package vga_text_wr_pkg;

    typedef enum logic [1:0] {
        OP_PUT   = 2'b00,
        OP_SETXY = 2'b01,
        OP_CLEAR = 2'b10,
        OP_COLOR = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_CLR  = 2'd2
    } state_e;

    localparam int          DEF_COLS      = 80;
    localparam int          DEF_ROWS      = 30;
    localparam logic [11:0] DEF_CTRL_ADDR = 12'h800;

    // Control-character codes (7-bit, the inverse-video bit is not part of the code)
    localparam logic [6:0] CH_LF = 7'h0A;
    localparam logic [6:0] CH_CR = 7'h0D;
    localparam logic [6:0] CH_BS = 7'h08;

    function automatic logic is_ctrl_char(input logic [6:0] code);
        return (code == CH_LF) || (code == CH_CR) || (code == CH_BS);
    endfunction

endpackage

// File: rtl/vga_text_cursor.sv
// Text cursor register pair: range-checked load, home, advance with
// row/screen wrap, and the line-feed / carriage-return / backspace moves.
module vga_text_cursor
    import vga_text_wr_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_advance,
    input  logic       i_set,
    input  logic [6:0] i_set_col,
    input  logic [4:0] i_set_row,
    input  logic       i_home,
    input  logic       i_ctrl_lf,
    input  logic       i_ctrl_cr,
    input  logic       i_ctrl_bs,
    output logic [6:0] o_col,
    output logic [4:0] o_row,
    output logic       o_err
);

    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    logic       w_set_ok;
    logic [4:0] w_row_next;

    assign w_set_ok   = (int'(i_set_col) < COLS) && (int'(i_set_row) < ROWS);
    // Next row with wrap to the top; there is no scrolling
    assign w_row_next = (o_row == LAST_ROW) ? 5'd0 : o_row + 5'd1;

    // Cursor position and one-cycle drop pulse for an out-of-range load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_col <= 7'd0;
            o_row <= 5'd0;
            o_err <= 1'b0;
        end else begin
            o_err <= i_set && !w_set_ok;
            if (i_set) begin
                if (w_set_ok) begin
                    o_col <= i_set_col;
                    o_row <= i_set_row;
                end
            end else if (i_home) begin
                o_col <= 7'd0;
                o_row <= 5'd0;
            end else if (i_advance) begin
                if (o_col == LAST_COL) begin
                    o_col <= 7'd0;
                    o_row <= w_row_next;
                end else begin
                    o_col <= o_col + 7'd1;
                end
            end else if (i_ctrl_lf) begin
                o_col <= 7'd0;
                o_row <= w_row_next;
            end else if (i_ctrl_cr) begin
                o_col <= 7'd0;
            end else if (i_ctrl_bs && (o_col != 7'd0)) begin
                o_col <= o_col - 7'd1;
            end
        end
    end

endmodule

// File: rtl/vga_text_avl_writer.sv
// Avalon-MM master turning PUT / SETXY / CLEAR / COLOR commands into writes
// to the VGA text slave's VRAM and control register.
// Optional build macro VGA_TEXT_WR_CTRL_CHAR_EN: PUT of LF / CR / BS moves the
// cursor without a bus write; when undefined every code is written as a glyph.
module vga_text_avl_writer
    import vga_text_wr_pkg::*;
#(
    parameter int          COLS      = DEF_COLS,
    parameter int          ROWS      = DEF_ROWS,
    parameter logic [11:0] CTRL_ADDR = DEF_CTRL_ADDR
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_data,
    output logic        cmd_err,
    output logic        busy,
    output logic [6:0]  cursor_col,
    output logic [4:0]  cursor_row,
    output logic [11:0] avm_address,
    output logic        avm_chipselect,
    output logic        avm_write,
    output logic [3:0]  avm_byteenable,
    output logic [31:0] avm_writedata,
    input  logic        avm_waitrequest
);

    localparam int          WORDS     = COLS * ROWS / 4;
    localparam int          WPR       = COLS / 4;
    localparam logic [11:0] LAST_WORD = 12'(WORDS - 1);

    state_e      r_state;
    state_e      w_next;
    logic [11:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_data;
    logic        r_is_put;

    cmd_op_e     w_op;
    logic        w_accept;
    logic        w_done;
    logic        w_ctrl_lf;
    logic        w_ctrl_cr;
    logic        w_ctrl_bs;
    logic        w_ctrl;
    logic [11:0] w_put_addr;
    logic        w_clr_last;

    assign w_op       = cmd_op_e'(cmd_op);
    assign cmd_ready  = (r_state == ST_IDLE) && !RESET;
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_done     = !avm_waitrequest;
    assign w_put_addr = 12'(cursor_row) * 12'(WPR) + 12'(cursor_col[6:2]);
    assign w_clr_last = (r_addr == LAST_WORD);

`ifdef VGA_TEXT_WR_CTRL_CHAR_EN
    assign w_ctrl_lf = w_accept && (w_op == OP_PUT) && (cmd_data[6:0] == CH_LF);
    assign w_ctrl_cr = w_accept && (w_op == OP_PUT) && (cmd_data[6:0] == CH_CR);
    assign w_ctrl_bs = w_accept && (w_op == OP_PUT) && (cmd_data[6:0] == CH_BS);
`else
    assign w_ctrl_lf = 1'b0;
    assign w_ctrl_cr = 1'b0;
    assign w_ctrl_bs = 1'b0;
`endif
    assign w_ctrl = w_ctrl_lf || w_ctrl_cr || w_ctrl_bs;

    // Bus strobes come straight from the state so reset drops them at once
    assign avm_write      = (r_state == ST_WR) || (r_state == ST_CLR);
    assign avm_chipselect = avm_write;
    assign busy           = (r_state != ST_IDLE);
    assign avm_address    = r_addr;
    assign avm_byteenable = r_be;
    assign avm_writedata  = r_data;

    // State register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (w_op)
                        OP_PUT:   if (!w_ctrl) w_next = ST_WR;
                        OP_COLOR: w_next = ST_WR;
                        OP_CLEAR: w_next = ST_CLR;
                        default:  w_next = ST_IDLE;
                    endcase
                end
            end
            ST_WR:   if (w_done) w_next = ST_IDLE;
            ST_CLR:  if (w_done && w_clr_last) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Transfer registers: latched on acceptance, held while stalled,
    // address doubles as the word counter during CLEAR
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_addr   <= 12'd0;
            r_be     <= 4'd0;
            r_data   <= 32'd0;
            r_is_put <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_is_put <= (w_op == OP_PUT);
                        case (w_op)
                            OP_PUT: begin
                                if (!w_ctrl) begin
                                    r_addr <= w_put_addr;
                                    r_be   <= 4'b0001 << cursor_col[1:0];
                                    r_data <= {4{cmd_data[7:0]}};
                                end
                            end
                            OP_CLEAR: begin
                                r_addr <= 12'd0;
                                r_be   <= 4'hF;
                                r_data <= 32'd0;
                            end
                            OP_COLOR: begin
                                r_addr <= CTRL_ADDR;
                                r_be   <= 4'hF;
                                r_data <= cmd_data;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_CLR: begin
                    if (w_done && !w_clr_last) r_addr <= r_addr + 12'd1;
                end
                default: ;
            endcase
        end
    end

    vga_text_cursor #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_cursor (
        .clk       (CLK),
        .rst       (RESET),
        .i_advance ((r_state == ST_WR) && w_done && r_is_put),
        .i_set     (w_accept && (w_op == OP_SETXY)),
        .i_set_col (cmd_data[6:0]),
        .i_set_row (cmd_data[12:8]),
        .i_home    ((r_state == ST_CLR) && w_done && w_clr_last),
        .i_ctrl_lf (w_ctrl_lf),
        .i_ctrl_cr (w_ctrl_cr),
        .i_ctrl_bs (w_ctrl_bs),
        .o_col     (cursor_col),
        .o_row     (cursor_row),
        .o_err     (cmd_err)
    );

endmodule

// File: tb/tb_vga_text_avl_writer.sv
// Directed bench for vga_text_avl_writer with a screen-level reference model.
module tb_vga_text_avl_writer;

    localparam int COLS = 80;
    localparam int ROWS = 30;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_data;
    logic        cmd_err;
    logic        busy;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic [11:0] avm_address;
    logic        avm_chipselect;
    logic        avm_write;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;

    vga_text_avl_writer dut (
        .CLK(CLK), .RESET(RESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .cmd_err(cmd_err), .busy(busy), .cursor_col(cursor_col), .cursor_row(cursor_row),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_write(avm_write),
        .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
        .avm_waitrequest(avm_waitrequest)
    );

    always #10 CLK = ~CLK;

    typedef struct packed {
        logic [11:0] a;
        logic [3:0]  be;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t last_wr;
    wr_t prev_wr;
    logic prev_stall;
    int n_checks, n_fail;
    int m_col, m_row, exp_err;
    int wr_cnt, err_cnt, a10_cnt;
    int stall_addr, stall_len, stall_cnt;
    int cyc, w0, e0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic m_advance();
        int lin;
        lin   = (m_row * COLS + m_col + 1) % (COLS * ROWS);
        m_col = lin % COLS;
        m_row = lin / COLS;
    endtask

    task automatic m_push(input logic [11:0] a, input logic [3:0] be, input logic [31:0] d);
        wr_t w;
        w.a = a; w.be = be; w.d = d;
        exp_q.push_back(w);
    endtask

    task automatic m_put(input logic [7:0] b);
`ifdef VGA_TEXT_WR_CTRL_CHAR_EN
        if (b[6:0] == 7'h0A) begin m_col = 0; m_row = (m_row + 1) % ROWS; return; end
        if (b[6:0] == 7'h0D) begin m_col = 0; return; end
        if (b[6:0] == 7'h08) begin if (m_col > 0) m_col--; return; end
`endif
        m_push(12'(m_row * (COLS / 4) + m_col / 4), 4'(1 << (m_col % 4)), {4{b}});
        m_advance();
    endtask

    task automatic m_cmd(input logic [1:0] op, input logic [31:0] d);
        case (op)
            2'b00: m_put(d[7:0]);
            2'b01: begin
                if (int'(d[6:0]) < COLS && int'(d[12:8]) < ROWS) begin
                    m_col = int'(d[6:0]);
                    m_row = int'(d[12:8]);
                end else exp_err++;
            end
            2'b10: begin
                for (int i = 0; i < COLS * ROWS / 4; i++) m_push(12'(i), 4'hF, 32'd0);
                m_col = 0; m_row = 0;
            end
            default: m_push(12'h800, 4'hF, d);
        endcase
    endtask

    // ---------------- slave stall generator and bus monitor ----------------
    task automatic stall_step();
        if (!busy) stall_cnt = 0;
        if (avm_write && int'(avm_address) == stall_addr && stall_cnt < stall_len) begin
            avm_waitrequest = 1'b1;
            stall_cnt++;
        end else begin
            avm_waitrequest = 1'b0;
        end
    endtask

    task automatic mon_step();
        wr_t cur;
        wr_t e;
        cur.a = avm_address; cur.be = avm_byteenable; cur.d = avm_writedata;
        chk("chipselect_eq_write", avm_chipselect, avm_write);
        if (prev_stall) chk("hold_during_wait", cur, prev_wr);
        if (cmd_err) err_cnt++;
        if (avm_write && avm_address == 12'd10) a10_cnt++;
        if (avm_write && !avm_waitrequest) begin
            wr_cnt++;
            last_wr = cur;
            if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_write: got %0h, expected none", cur);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr_be_data", cur, e);
            end
        end
        prev_stall = avm_write && avm_waitrequest;
        prev_wr    = cur;
    endtask

    task automatic tick();
        @(negedge CLK);
        stall_step();
        mon_step();
    endtask

    // ---------------- command driver ----------------
    task automatic send(input logic [1:0] op, input logic [31:0] d);
        int n;
        cmd_op = op; cmd_data = d; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 2000) begin tick(); n++; end
        if (!cmd_ready) begin
            n_checks++; n_fail++;
            $display("FAIL cmd_accept_timeout: got cmd_ready=0, expected 1");
        end else begin
            tick();
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(output int c);
        c = 0;
        while (busy && c < 2000) begin c++; tick(); end
        if (busy) begin
            n_checks++; n_fail++;
            $display("FAIL idle_timeout: got busy=1, expected 0");
        end
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [31:0] d, output int c);
        m_cmd(op, d);
        send(op, d);
        wait_idle(c);
    endtask

    function automatic logic [31:0] xy(input int c, input int r);
        return {19'd0, 5'(r), 1'b0, 7'(c)};
    endfunction

    task automatic chk_cursor(input string name);
        chk({name, "_col"}, cursor_col, 7'(m_col));
        chk({name, "_row"}, cursor_row, 5'(m_row));
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        m_col = 0; m_row = 0; exp_err = 0;
        wr_cnt = 0; err_cnt = 0; a10_cnt = 0;
        stall_addr = -1; stall_len = 0; stall_cnt = 0;
        prev_stall = 1'b0; prev_wr = '0; last_wr = '0;
        RESET = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 32'd0;
        avm_waitrequest = 1'b0;

        // reset state
        repeat (3) tick();
        chk("rst_write", avm_write, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", cmd_err, 1'b0);
        chk("rst_ready", cmd_ready, 1'b0);
        chk("rst_addr_be_data", {avm_address, avm_byteenable, avm_writedata}, 48'd0);
        chk("rst_cursor", {cursor_row, cursor_col}, 12'd0);
        RESET = 1'b0;
        tick();
        chk("ready_after_reset", cmd_ready, 1'b1);

        // SETXY (13,2) then PUT 'A'
        do_cmd(2'b01, xy(13, 2), cyc);
        chk("setxy_busy_cycles", cyc, 0);
        chk_cursor("setxy_13_2");
        do_cmd(2'b00, 32'h41, cyc);
        chk("put_busy_cycles", cyc, 1);
        chk("put_addr", last_wr.a, 12'h02B);
        chk("put_be", last_wr.be, 4'b0010);
        chk("put_data", last_wr.d, 32'h41414141);
        chk("put_cursor_col", cursor_col, 7'd14);
        chk_cursor("after_put");

        // last cell, inverse video, screen wrap
        do_cmd(2'b01, xy(79, 29), cyc);
        do_cmd(2'b00, 32'hC1, cyc);
        chk("last_addr", last_wr.a, 12'h257);
        chk("last_be", last_wr.be, 4'b1000);
        chk("last_data", last_wr.d, 32'hC1C1C1C1);
        chk("wrap_cursor", {cursor_row, cursor_col}, 12'd0);

        // PUTs across a word boundary, first one stalled by the slave
        do_cmd(2'b01, xy(2, 5), cyc);
        stall_addr = 100; stall_len = 2;
        do_cmd(2'b00, 32'h61, cyc);
        chk("stalled_put_busy_cycles", cyc, 3);
        stall_len = 0;
        do_cmd(2'b00, 32'h62, cyc);
        do_cmd(2'b00, 32'h63, cyc);
        do_cmd(2'b00, 32'h64, cyc);
        chk("put_seq_be", last_wr.be, 4'b0010);
        chk_cursor("put_seq");

        // CLEAR with a 3-cycle stall on word 10
        do_cmd(2'b01, xy(5, 5), cyc);
        stall_addr = 10; stall_len = 3; a10_cnt = 0; w0 = wr_cnt;
        do_cmd(2'b10, 32'd0, cyc);
        stall_len = 0;
        chk("clear_busy_cycles", cyc, 603);
        chk("clear_addr10_cycles", a10_cnt, 4);
        chk("clear_write_count", wr_cnt - w0, 600);
        chk("clear_cursor", {cursor_row, cursor_col}, 12'd0);
        chk("clear_queue_drained", exp_q.size(), 0);

        // out-of-range SETXY
        do_cmd(2'b01, xy(3, 4), cyc);
        e0 = err_cnt; w0 = wr_cnt;
        do_cmd(2'b01, xy(80, 5), cyc);
        do_cmd(2'b01, xy(0, 30), cyc);
        chk("setxy_err_pulses", err_cnt - e0, 2);
        chk("setxy_no_write", wr_cnt - w0, 0);
        chk_cursor("setxy_unchanged");

        // COLOR
        do_cmd(2'b11, 32'h01FFE000, cyc);
        chk("color_addr", last_wr.a, 12'h800);
        chk("color_be", last_wr.be, 4'hF);
        chk("color_data", last_wr.d, 32'h01FFE000);
        chk_cursor("color_cursor");

        // control characters
        do_cmd(2'b01, xy(5, 3), cyc);
        w0 = wr_cnt;
        do_cmd(2'b00, 32'h0A, cyc);
`ifdef VGA_TEXT_WR_CTRL_CHAR_EN
        chk("lf_busy_cycles", cyc, 0);
        chk("lf_no_write", wr_cnt - w0, 0);
        chk("lf_cursor", {cursor_row, cursor_col}, {5'd4, 7'd0});
        do_cmd(2'b00, 32'h08, cyc);
        chk("bs_at_col0_cursor", {cursor_row, cursor_col}, {5'd4, 7'd0});
        chk("bs_no_write", wr_cnt - w0, 0);
`else
        chk("lf_glyph_addr", last_wr.a, 12'h03D);
        chk("lf_glyph_be", last_wr.be, 4'b0010);
        chk("lf_glyph_data", last_wr.d, 32'h0A0A0A0A);
`endif
        chk_cursor("ctrl_char");

        // RESET in the middle of CLEAR
        do_cmd(2'b01, xy(7, 7), cyc);
        m_cmd(2'b10, 32'd0);
        send(2'b10, 32'd0);
        repeat (49) tick();
        RESET = 1'b1;
        #1;
        chk("reset_drops_write", avm_write, 1'b0);
        chk("reset_drops_busy", busy, 1'b0);
        exp_q.delete();
        m_col = 0; m_row = 0;
        repeat (2) tick();
        RESET = 1'b0;
        tick();
        chk("post_reset_ready", cmd_ready, 1'b1);
        chk("post_reset_busy", busy, 1'b0);
        chk_cursor("post_reset");
        do_cmd(2'b00, 32'h5A, cyc);
        chk("post_reset_put_addr", last_wr.a, 12'h000);

        chk("err_total", err_cnt, exp_err);
        chk("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
